phy_rx_lanes: RTL and testbench

- Parametrised multi-lane PHY receiver on a single clk_32f domain.
- Each of LANES serial inputs is word-aligned by hunting for a COM symbol, then deserialised into bytes and assembled into WORD_W-bit words.
- Each lane buffers its words in a FIFO that absorbs inter-lane skew.
- A round-robin unstriper re-interleaves the lanes into one word stream. Derived clocks are replaced by internal bit/byte counters.

---
 rtl/phy_rx_lanes_if.sv | 23 ++
 rtl/phy_rx_lanes.sv | 187 ++++++++++++++++++
 tb/tb_phy_rx_lanes.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_rx_lanes_if.sv
// Bundle of the receiver's serial inputs and its word/status outputs.
// master = the side driving the lanes, slave = the receiver itself.
interface phy_rx_lanes_if #(
    parameter int LANES  = 2,
    parameter int WORD_W = 32
);
    logic [LANES-1:0]  serial_in;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic [LANES-1:0]  lane_active;
    logic [LANES-1:0]  overflow;
    logic [LANES-1:0]  align_err;

    modport master (
        output serial_in,
        input  data_out, valid_out, lane_active, overflow, align_err
    );

    modport slave (
        input  serial_in,
        output data_out, valid_out, lane_active, overflow, align_err
    );
endinterface

// File: rtl/phy_rx_lanes.sv
// Multi-lane serial receiver: per-lane COM alignment, byte/word assembly,
// skew-absorbing lane FIFOs and a strict round-robin unstriper.
module phy_rx_lanes #(
    parameter int          LANES      = 2,
    parameter int          WORD_W     = 32,
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int          LOCK_COUNT = 4,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    phy_rx_lanes_if.slave bus
);

    localparam int BYTES = WORD_W / 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = $clog2(LOCK_COUNT + 1);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} laneState_e;

    laneState_e        state_q   [LANES];
    logic [6:0]        shift_q   [LANES];
    logic [2:0]        bitCnt_q  [LANES];
    logic [CW-1:0]     comCnt_q  [LANES];
    logic [BIW-1:0]    byteIdx_q [LANES];
    logic [WORD_W-1:0] acc_q     [LANES];
    logic [WORD_W-1:0] mem_q     [LANES][FIFO_DEPTH];
    logic [AW-1:0]     wrIdx_q   [LANES];
    logic [AW-1:0]     rdIdx_q   [LANES];
    logic [CNTW-1:0]   count_q   [LANES];
    logic [LANES-1:0]  wordValid_q;
    logic [LANES-1:0]  active_q;
    logic [LANES-1:0]  overflow_q;
    logic [LANES-1:0]  alignErr_q;
    logic [PW-1:0]     rrPtr_q;
    logic [WORD_W-1:0] dataOut_q;
    logic              validOut_q;

    logic [7:0]        testByte [LANES];
    logic [WORD_W-1:0] nextAcc  [LANES];
    logic [LANES-1:0]  boundary;
    logic [LANES-1:0]  full;
    logic [LANES-1:0]  empty;
    logic [LANES-1:0]  push;
    logic [LANES-1:0]  drop;
    logic [LANES-1:0]  pop;
    logic              popValid;
    logic [WORD_W-1:0] headWord;

    // The byte under test includes the bit arriving on this edge, so alignment
    // decisions and word completion happen on the edge that samples the last bit.
    always_comb begin
        popValid = 1'b0;
        headWord = '0;
        for (int i = 0; i < LANES; i++) begin
            testByte[i] = {shift_q[i], bus.serial_in[i]};
            nextAcc[i]  = (acc_q[i] << 8) | WORD_W'(testByte[i]);
            boundary[i] = (bitCnt_q[i] == 3'd7);
            empty[i]    = (count_q[i] == '0);
            full[i]     = (count_q[i] == CNTW'(FIFO_DEPTH));
        end
        popValid = (&active_q) && !empty[rrPtr_q];
        headWord = mem_q[rrPtr_q][rdIdx_q[rrPtr_q]];
        for (int i = 0; i < LANES; i++) begin
            pop[i]  = popValid && (rrPtr_q == PW'(i));
            push[i] = wordValid_q[i] && (!full[i] || pop[i]);
            drop[i] = wordValid_q[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i]   <= SEARCH;
                shift_q[i]   <= '0;
                bitCnt_q[i]  <= '0;
                comCnt_q[i]  <= '0;
                byteIdx_q[i] <= '0;
                acc_q[i]     <= '0;
                wrIdx_q[i]   <= '0;
                rdIdx_q[i]   <= '0;
                count_q[i]   <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    mem_q[i][d] <= '0;
                end
            end
            wordValid_q <= '0;
            active_q    <= '0;
            overflow_q  <= '0;
            alignErr_q  <= '0;
            rrPtr_q     <= '0;
            dataOut_q   <= '0;
            validOut_q  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                shift_q[i]     <= testByte[i][6:0];
                wordValid_q[i] <= 1'b0;

                case (state_q[i])
                    SEARCH: begin
                        if (testByte[i] == COM) begin
                            bitCnt_q[i] <= '0;
                            comCnt_q[i] <= CW'(1);
                            if (LOCK_COUNT == 1) begin
                                state_q[i]  <= ACTIVE;
                                active_q[i] <= 1'b1;
                            end else begin
                                state_q[i] <= LOCKING;
                            end
                        end
                    end
                    LOCKING: begin
                        bitCnt_q[i] <= bitCnt_q[i] + 3'd1;
                        if (boundary[i]) begin
                            if (testByte[i] == COM) begin
                                comCnt_q[i] <= comCnt_q[i] + CW'(1);
                                if (comCnt_q[i] == CW'(LOCK_COUNT - 1)) begin
                                    state_q[i]  <= ACTIVE;
                                    active_q[i] <= 1'b1;
                                end
                            end else begin
                                state_q[i]  <= SEARCH;
                                comCnt_q[i] <= '0;
                            end
                        end
                    end
                    ACTIVE: begin
                        bitCnt_q[i] <= bitCnt_q[i] + 3'd1;
                        if (boundary[i]) begin
                            // A COM in the middle of a word means the partial word is garbage.
                            if (testByte[i] == COM) begin
                                if (byteIdx_q[i] != '0) begin
                                    byteIdx_q[i]  <= '0;
                                    alignErr_q[i] <= 1'b1;
                                end
                            end else begin
                                acc_q[i] <= nextAcc[i];
                                if (byteIdx_q[i] == BIW'(BYTES - 1)) begin
                                    wordValid_q[i] <= 1'b1;
                                    byteIdx_q[i]   <= '0;
                                end else begin
                                    byteIdx_q[i] <= byteIdx_q[i] + BIW'(1);
                                end
                            end
                        end
                    end
                    default: state_q[i] <= SEARCH;
                endcase

                // acc_q is untouched on the edge after completion, so it still holds the word.
                if (push[i]) begin
                    mem_q[i][wrIdx_q[i]] <= acc_q[i];
                    wrIdx_q[i] <= (wrIdx_q[i] == AW'(FIFO_DEPTH - 1)) ? '0 : wrIdx_q[i] + AW'(1);
                end
                if (drop[i]) begin
                    overflow_q[i] <= 1'b1;
                end
                if (pop[i]) begin
                    rdIdx_q[i] <= (rdIdx_q[i] == AW'(FIFO_DEPTH - 1)) ? '0 : rdIdx_q[i] + AW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNTW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CNTW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end

            if (popValid) begin
                dataOut_q  <= headWord;
                validOut_q <= 1'b1;
                rrPtr_q    <= (rrPtr_q == PW'(LANES - 1)) ? '0 : rrPtr_q + PW'(1);
            end else begin
                validOut_q <= 1'b0;
            end
        end
    end

    assign bus.data_out    = dataOut_q;
    assign bus.valid_out   = validOut_q;
    assign bus.lane_active = active_q;
    assign bus.overflow    = overflow_q;
    assign bus.align_err   = alignErr_q;

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Scoreboarded bench for phy_rx_lanes: a 2-lane/32-bit instance and a
// 4-lane/16-bit instance share one bit clock and one expected-word queue.
module tb_phy_rx_lanes;

    localparam logic [7:0] COM = 8'hBC;

    logic clk;
    logic reset1_L;
    logic reset2_L;

    phy_rx_lanes_if #(.LANES(2), .WORD_W(32)) if1 ();
    phy_rx_lanes_if #(.LANES(4), .WORD_W(16)) if2 ();

    phy_rx_lanes #(.LANES(2), .WORD_W(32), .COM(8'hBC), .LOCK_COUNT(4), .FIFO_DEPTH(4)) dut1 (
        .clk_32f (clk),
        .reset_L (reset1_L),
        .bus     (if1)
    );

    phy_rx_lanes #(.LANES(4), .WORD_W(16), .COM(8'hBC), .LOCK_COUNT(4), .FIFO_DEPTH(4)) dut2 (
        .clk_32f (clk),
        .reset_L (reset2_L),
        .bus     (if2)
    );

    int          vectorsApplied = 0;
    int          miscompares    = 0;
    int          cycleCount     = 0;
    int          startCycle     = 0;
    int          firstValidCycle = -1;
    int          riseCycle [2];
    logic [31:0] sbQ [$];
    logic [31:0] expWord1;
    logic [31:0] expWord2;
    bit          streamBits [4][1024];
    int          streamLen [4];
    logic [7:0]  idleByte [4];
    logic [15:0] w0 [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Scoreboard: every output pulse of either instance consumes the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (if1.valid_out === 1'b1) begin
                if (firstValidCycle < 0) firstValidCycle = cycleCount;
                vectorsApplied++;
                if (sbQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL dut1_unexpected_word got %h required no word", if1.data_out);
                end else begin
                    expWord1 = sbQ.pop_front();
                    if (if1.data_out !== expWord1) begin
                        miscompares++;
                        $display("[TB] FAIL dut1_word got %h required %h", if1.data_out, expWord1);
                    end
                end
            end
            if (if2.valid_out === 1'b1) begin
                vectorsApplied++;
                if (sbQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL dut2_unexpected_word got %h required no word", if2.data_out);
                end else begin
                    expWord2 = sbQ.pop_front();
                    if (if2.data_out !== expWord2[15:0]) begin
                        miscompares++;
                        $display("[TB] FAIL dut2_word got %h required %h", if2.data_out, expWord2[15:0]);
                    end
                end
            end
        end
    end

    task automatic clearStreams();
        for (int i = 0; i < 4; i++) begin
            streamLen[i] = 0;
            idleByte[i]  = COM;
        end
    endtask

    task automatic addBit(input int lane, input bit b);
        streamBits[lane][streamLen[lane]] = b;
        streamLen[lane]++;
    endtask

    task automatic addByte(input int lane, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) addBit(lane, b[k]);
    endtask

    task automatic addComs(input int lane, input int n);
        for (int k = 0; k < n; k++) addByte(lane, COM);
    endtask

    task automatic addWord(input int lane, input logic [31:0] w, input int nBytes);
        for (int k = nBytes - 1; k >= 0; k--) addByte(lane, w[k*8 +: 8]);
    endtask

    function automatic logic [15:0] randWord16();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:8] == COM) w[15:8] = 8'h3C;
        if (w[7:0] == COM) w[7:0] = 8'h3C;
        return w;
    endfunction

    task automatic resetAll();
        @(negedge clk);
        reset1_L = 1'b0;
        reset2_L = 1'b0;
        if1.serial_in = '0;
        if2.serial_in = '0;
        repeat (2) @(negedge clk);
        reset1_L = 1'b1;
        reset2_L = 1'b1;
    endtask

    // Plays the built streams one bit per cycle; a lane past its stream end
    // repeats its idle byte, keeping the byte alignment it already had.
    task automatic applyStimulus(input int sel, input int extra);
        int nl;
        int maxLen;
        int k;
        logic [3:0] v;
        nl = (sel == 1) ? 2 : 4;
        maxLen = 0;
        for (int i = 0; i < nl; i++) if (streamLen[i] > maxLen) maxLen = streamLen[i];
        for (int j = 0; j < maxLen + extra; j++) begin
            @(negedge clk);
            if (j == 0) startCycle = cycleCount;
            v = '0;
            for (int i = 0; i < nl; i++) begin
                k = j - streamLen[i];
                if (k < 0) v[i] = streamBits[i][j];
                else       v[i] = idleByte[i][7 - (k % 8)];
            end
            if (sel == 1) begin
                for (int i = 0; i < 2; i++)
                    if (if1.lane_active[i] === 1'b1 && riseCycle[i] < 0) riseCycle[i] = cycleCount;
                if1.serial_in = v[1:0];
            end else begin
                if2.serial_in = v;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectorsApplied++;
        if ({if1.data_out, if1.valid_out, if1.lane_active, if1.overflow, if1.align_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut1 got data=%h v=%b act=%b ovf=%b aerr=%b required all 0",
                     if1.data_out, if1.valid_out, if1.lane_active, if1.overflow, if1.align_err);
        end
        vectorsApplied++;
        if ({if2.data_out, if2.valid_out, if2.lane_active, if2.overflow, if2.align_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut2 got data=%h v=%b act=%b ovf=%b aerr=%b required all 0",
                     if2.data_out, if2.valid_out, if2.lane_active, if2.overflow, if2.align_err);
        end
        reset1_L = 1'b1;
        reset2_L = 1'b1;
    endtask

    task automatic test_basic();
        resetAll();
        clearStreams();
        addComs(0, 4);
        addComs(1, 4);
        addWord(0, 32'hA1A2A3A4, 4);
        addWord(1, 32'hB1B2B3B4, 4);
        addWord(0, 32'hC1C2C3C4, 4);
        addWord(1, 32'hD1D2D3D4, 4);
        sbQ.push_back(32'hA1A2A3A4);
        sbQ.push_back(32'hB1B2B3B4);
        sbQ.push_back(32'hC1C2C3C4);
        sbQ.push_back(32'hD1D2D3D4);
        riseCycle[0] = -1;
        riseCycle[1] = -1;
        firstValidCycle = -1;
        applyStimulus(1, 40);
        vectorsApplied++;
        if (if1.lane_active !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL basic_lane_active got %b required 11", if1.lane_active);
        end
        vectorsApplied++;
        if (riseCycle[0] != startCycle + 32 || riseCycle[1] != startCycle + 32) begin
            miscompares++;
            $display("[TB] FAIL basic_lock_cycle got %0d/%0d required %0d", riseCycle[0] - startCycle,
                     riseCycle[1] - startCycle, 32);
        end
        vectorsApplied++;
        if (firstValidCycle != startCycle + 66) begin
            miscompares++;
            $display("[TB] FAIL basic_latency got %0d required %0d", firstValidCycle - startCycle, 66);
        end
        vectorsApplied++;
        if ({if1.overflow, if1.align_err} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL basic_status got ovf=%b aerr=%b required 00/00", if1.overflow, if1.align_err);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL basic_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_skew();
        resetAll();
        clearStreams();
        for (int k = 0; k < 3; k++) addBit(0, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 13; k++) addBit(1, 1'b0);
        addComs(0, 4);
        addComs(1, 4);
        addWord(0, 32'hA1A2A3A4, 4);
        addWord(1, 32'hB1B2B3B4, 4);
        addWord(0, 32'hC1C2C3C4, 4);
        addWord(1, 32'hD1D2D3D4, 4);
        sbQ.push_back(32'hA1A2A3A4);
        sbQ.push_back(32'hB1B2B3B4);
        sbQ.push_back(32'hC1C2C3C4);
        sbQ.push_back(32'hD1D2D3D4);
        riseCycle[0] = -1;
        riseCycle[1] = -1;
        applyStimulus(1, 60);
        vectorsApplied++;
        if (riseCycle[0] != startCycle + 35) begin
            miscompares++;
            $display("[TB] FAIL skew_lock0 got %0d required 35", riseCycle[0] - startCycle);
        end
        vectorsApplied++;
        if (riseCycle[1] != startCycle + 45) begin
            miscompares++;
            $display("[TB] FAIL skew_lock1 got %0d required 45", riseCycle[1] - startCycle);
        end
        vectorsApplied++;
        if (if1.lane_active !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL skew_lane_active got %b required 11", if1.lane_active);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL skew_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_false_lock();
        resetAll();
        clearStreams();
        addComs(0, 2);
        addByte(0, 8'h55);
        addComs(0, 4);
        addWord(0, 32'hE1E2E3E4, 4);
        addComs(1, 4);
        addWord(1, 32'hF1F2F3F4, 4);
        sbQ.push_back(32'hE1E2E3E4);
        sbQ.push_back(32'hF1F2F3F4);
        riseCycle[0] = -1;
        riseCycle[1] = -1;
        applyStimulus(1, 40);
        vectorsApplied++;
        if (riseCycle[0] != startCycle + 56) begin
            miscompares++;
            $display("[TB] FAIL false_lock_cycle got %0d required 56", riseCycle[0] - startCycle);
        end
        vectorsApplied++;
        if (if1.align_err !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL false_lock_align_err got %b required 00", if1.align_err);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL false_lock_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_align_err();
        resetAll();
        clearStreams();
        addComs(0, 4);
        addByte(0, 8'h11);
        addByte(0, 8'h22);
        addComs(0, 1);
        addWord(0, 32'h33445566, 4);
        addComs(1, 4);
        addWord(1, 32'h778899AA, 4);
        sbQ.push_back(32'h33445566);
        sbQ.push_back(32'h778899AA);
        riseCycle[0] = -1;
        riseCycle[1] = -1;
        applyStimulus(1, 40);
        vectorsApplied++;
        if (if1.align_err !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL align_err_flag got %b required 01", if1.align_err);
        end
        vectorsApplied++;
        if (if1.overflow !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL align_err_overflow got %b required 00", if1.overflow);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL align_err_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_overflow();
        resetAll();
        clearStreams();
        addComs(0, 4);
        for (int k = 0; k < 5; k++) addWord(0, 32'h11121314 + 32'h01010101 * k, 4);
        for (int k = 0; k < 200; k++) addBit(1, 1'b0);
        addComs(1, 4);
        for (int k = 0; k < 4; k++) addWord(1, 32'h21222324 + 32'h01010101 * k, 4);
        for (int k = 0; k < 4; k++) begin
            sbQ.push_back(32'h11121314 + 32'h01010101 * k);
            sbQ.push_back(32'h21222324 + 32'h01010101 * k);
        end
        riseCycle[0] = -1;
        riseCycle[1] = -1;
        applyStimulus(1, 40);
        vectorsApplied++;
        if (riseCycle[0] != startCycle + 32 || riseCycle[1] != startCycle + 232) begin
            miscompares++;
            $display("[TB] FAIL overflow_lock_cycles got %0d/%0d required 32/232",
                     riseCycle[0] - startCycle, riseCycle[1] - startCycle);
        end
        vectorsApplied++;
        if (if1.overflow !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL overflow_flag got %b required 01", if1.overflow);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL overflow_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_reset_midword();
        resetAll();
        clearStreams();
        for (int i = 0; i < 4; i++) begin
            w0[i] = randWord16();
            addComs(i, 4);
            addWord(i, {16'h0, w0[i]}, 2);
            sbQ.push_back({16'h0, w0[i]});
        end
        addByte(0, 8'h12);
        applyStimulus(2, 0);
        @(negedge clk);
        vectorsApplied++;
        if (if2.lane_active !== 4'hF || if2.data_out !== w0[3] || if2.align_err !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL midword_before got act=%b data=%h aerr=%b required 1111/%h/0000",
                     if2.lane_active, if2.data_out, if2.align_err, w0[3]);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midword_first_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
        #1 reset2_L = 1'b0;
        if2.serial_in = '0;
        #1;
        vectorsApplied++;
        if ({if2.data_out, if2.valid_out, if2.lane_active, if2.overflow, if2.align_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midword_reset got data=%h act=%b aerr=%b required all 0",
                     if2.data_out, if2.lane_active, if2.align_err);
        end
        repeat (2) @(negedge clk);
        reset2_L = 1'b1;
        clearStreams();
        for (int i = 0; i < 4; i++) begin
            w0[i] = randWord16();
            addComs(i, 4);
            addWord(i, {16'h0, w0[i]}, 2);
            sbQ.push_back({16'h0, w0[i]});
        end
        for (int i = 0; i < 4; i++) begin
            w0[i] = randWord16();
            addWord(i, {16'h0, w0[i]}, 2);
            sbQ.push_back({16'h0, w0[i]});
        end
        applyStimulus(2, 40);
        vectorsApplied++;
        if (if2.lane_active !== 4'hF || if2.align_err !== 4'h0 || if2.overflow !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL midword_relock got act=%b aerr=%b ovf=%b required 1111/0000/0000",
                     if2.lane_active, if2.align_err, if2.overflow);
        end
        vectorsApplied++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midword_drain got %0d pending required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        reset1_L = 1'b0;
        reset2_L = 1'b0;
        if1.serial_in = '0;
        if2.serial_in = '0;
        riseCycle[0] = -1;
        riseCycle[1] = -1;
        $display("[TB] starting phy_rx_lanes bench");
        test_reset();
        test_basic();
        test_skew();
        test_false_lock();
        test_align_err();
        test_overflow();
        test_reset_midword();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
